// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, defaults and helpers for the register-bus controller
//   Contents: bus_state_e (IDLE/DRIVE/WRITE), BUS_DATA_WIDTH / BUS_NUM_REGS defaults,
//             idx_in_range() register-index check.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_NUM_REGS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2
  } bus_state_e;

  // True when idx addresses a register that actually exists on the bus.
  function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/bus_src_mux.sv
// rtl/bus_src_mux.sv - combinational source-register slice select for the bus
//   i_bus  [NUM_REGS*DATA_WIDTH] : concatenated register outputs, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_sel  [SEL_W]               : source index
//   o_data [DATA_WIDTH]          : selected slice, zero for an index with no register
module bus_src_mux
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int NUM_REGS   = BUS_NUM_REGS,
  parameter int SEL_W      = 4
) (
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_bus,
  input  logic [SEL_W-1:0]               i_sel,
  output logic [DATA_WIDTH-1:0]          o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_data = i_bus[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// rtl/bus_transfer_ctrl.sv - register-to-register bus transfer controller (one transfer per 3 cycles)
//   clock, clear (async, active-high)
//   req_valid / req_ready, req_src, req_dst       : transfer request handshake
//   req_imm_sel, req_imm (only with BUS_IMM_EN)   : drive an immediate instead of a register
//   BusMuxIn  [NUM_REGS*DATA_WIDTH]               : register outputs
//   BusMuxOut [DATA_WIDTH]                        : registered bus value
//   enable    [NUM_REGS]                          : one-hot destination strobe (WRITE only)
//   done, err                                     : single-cycle completion / bad-index pulses
//   Optional feature macro: BUS_IMM_EN
module bus_transfer_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int NUM_REGS   = BUS_NUM_REGS,
  parameter int SEL_W      = 4
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [SEL_W-1:0]               req_src,
  input  logic [SEL_W-1:0]               req_dst,
`ifdef BUS_IMM_EN
  input  logic                           req_imm_sel,
  input  logic [DATA_WIDTH-1:0]          req_imm,
`endif
  input  logic [NUM_REGS*DATA_WIDTH-1:0] BusMuxIn,
  output logic [DATA_WIDTH-1:0]          BusMuxOut,
  output logic [NUM_REGS-1:0]            enable,
  output logic                           done,
  output logic                           err
);

  bus_state_e            r_state;
  bus_state_e            w_state_next;
  logic [SEL_W-1:0]      r_src;
  logic [SEL_W-1:0]      r_dst;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_bus;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [DATA_WIDTH-1:0] w_drive_data;
  logic                  w_accept;
  logic                  w_req_ok;
  logic                  w_dst_ok;

  // Acceptance depends only on state, so req_ready never looks at req_valid.
  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_dst_ok = idx_in_range($unsigned(32'(req_dst)), $unsigned(NUM_REGS));

`ifdef BUS_IMM_EN
  logic                  r_imm_sel;
  logic [DATA_WIDTH-1:0] r_imm;

  // An immediate transfer never reads the register bank, so its src is not checked.
  assign w_req_ok     = w_dst_ok &&
                        (req_imm_sel || idx_in_range($unsigned(32'(req_src)), $unsigned(NUM_REGS)));
  assign w_drive_data = r_imm_sel ? r_imm : w_src_data;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
    end else if (w_accept) begin
      r_imm_sel <= req_imm_sel;
      r_imm     <= req_imm;
    end
  end
`else
  assign w_req_ok     = w_dst_ok && idx_in_range($unsigned(32'(req_src)), $unsigned(NUM_REGS));
  assign w_drive_data = w_src_data;
`endif

  bus_src_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .SEL_W      (SEL_W)
  ) u_src_mux (
    .i_bus  (BusMuxIn),
    .i_sel  (r_src),
    .o_data (w_src_data)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // enable/done/req_ready are pure state decodes; clear resets the state
  // asynchronously, so an in-flight enable strobe drops the moment clear rises.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    done         = 1'b0;
    enable       = '0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept && w_req_ok) begin
          w_state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
        for (int i = 0; i < NUM_REGS; i++) begin
          enable[i] = (r_dst == SEL_W'(i));
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Indices are latched on every acceptance; a rejected request never leaves
  // IDLE, so the stale copies are harmless. The bus register loads at the edge
  // that ends DRIVE and otherwise holds.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_src <= '0;
      r_dst <= '0;
      r_err <= 1'b0;
      r_bus <= '0;
    end else begin
      r_err <= w_accept && !w_req_ok;
      if (w_accept) begin
        r_src <= req_src;
        r_dst <= req_dst;
      end
      if (r_state == ST_DRIVE) begin
        r_bus <= w_drive_data;
      end
    end
  end

  assign BusMuxOut = r_bus;
  assign err       = r_err;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb/tb_bus_transfer_ctrl.sv - self-checking bench for bus_transfer_ctrl (NUM_REGS=12)
module tb_bus_transfer_ctrl;

  localparam int DW = 32;
  localparam int NR = 12;
  localparam int SW = 4;

  logic             clock;
  logic             clear;
  logic             req_valid;
  logic             req_ready;
  logic [SW-1:0]    req_src;
  logic [SW-1:0]    req_dst;
  logic [NR*DW-1:0] BusMuxIn;
  logic [DW-1:0]    BusMuxOut;
  logic [NR-1:0]    enable;
  logic             done;
  logic             err;
`ifdef BUS_IMM_EN
  logic             req_imm_sel;
  logic [DW-1:0]    req_imm;
`endif

  bus_transfer_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_W(SW)) dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
`ifdef BUS_IMM_EN
    .req_imm_sel (req_imm_sel),
    .req_imm     (req_imm),
`endif
    .BusMuxIn  (BusMuxIn),
    .BusMuxOut (BusMuxOut),
    .enable    (enable),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank attached to the bus: captures BusMuxOut when its enable is high.
  logic [DW-1:0] bank      [NR];
  logic [DW-1:0] init_vals [NR];
  logic          init_bank;

  always @(posedge clock) begin
    for (int i = 0; i < NR; i++) begin
      if (init_bank) bank[i] <= init_vals[i];
      else if (enable[i]) bank[i] <= BusMuxOut;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) BusMuxIn[i*DW +: DW] = bank[i];
  end

  // Accept monitor for throughput checks.
  int cyc;
  int acc_q[$];
  initial cyc = 0;
  always @(posedge clock) begin
    if (req_valid && req_ready && !clear) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  // Reference model: register contents and the value the bus should hold.
  logic [DW-1:0] exp_regs [16];
  logic [DW-1:0] exp_bus;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request from an idle negedge through to the cycle after completion.
  task automatic run_xfer(input logic [3:0] src, input logic [3:0] dst, input bit exp_err);
    logic [DW-1:0] bus_before;
    bus_before = exp_bus;
    check("idle.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_src   = src;
    req_dst   = dst;
    @(negedge clock);
    req_valid = 1'b0;
    check("acc.err", 32'(err), 32'(exp_err));
    check("acc.ready", 32'(req_ready), 32'(exp_err));
    check("acc.enable", 32'(enable), 32'd0);
    check("acc.done", 32'(done), 32'd0);
    check("acc.bus_hold", BusMuxOut, bus_before);
    if (exp_err) begin
      @(negedge clock);
      check("err.one_cycle", 32'(err), 32'd0);
      check("err.bus_hold", BusMuxOut, bus_before);
      return;
    end
    @(negedge clock);
    exp_bus = exp_regs[src];
    check("wr.bus", BusMuxOut, exp_bus);
    check("wr.enable", 32'(enable), 32'd1 << dst);
    check("wr.done", 32'(done), 32'd1);
    check("wr.ready", 32'(req_ready), 32'd0);
    check("wr.err", 32'(err), 32'd0);
    exp_regs[dst] = exp_bus;
    @(negedge clock);
    check("post.ready", 32'(req_ready), 32'd1);
    check("post.enable", 32'(enable), 32'd0);
    check("post.done", 32'(done), 32'd0);
    check("post.dst_reg", bank[dst], exp_regs[dst]);
    check("post.bus_hold", BusMuxOut, exp_bus);
  endtask

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] r1_orig;
    int            n;

    vecs[0] = '{src: 4'd3,  dst: 4'd7,  exp_err: 1'b0};
    vecs[1] = '{src: 4'd13, dst: 4'd2,  exp_err: 1'b1};
    vecs[2] = '{src: 4'd7,  dst: 4'd7,  exp_err: 1'b0};
    vecs[3] = '{src: 4'd0,  dst: 4'd11, exp_err: 1'b0};
    vecs[4] = '{src: 4'd11, dst: 4'd0,  exp_err: 1'b0};
    vecs[5] = '{src: 4'd12, dst: 4'd3,  exp_err: 1'b1};
    vecs[6] = '{src: 4'd4,  dst: 4'd15, exp_err: 1'b1};
    vecs[7] = '{src: 4'd9,  dst: 4'd1,  exp_err: 1'b0};

    n_cmp = 0;
    n_bad = 0;
    clear     = 1'b1;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
`ifdef BUS_IMM_EN
    req_imm_sel = 1'b0;
    req_imm     = '0;
`endif
    for (int i = 0; i < NR; i++) init_vals[i] = $urandom();
    init_vals[3] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) exp_regs[i] = (i < NR) ? init_vals[i] : '0;
    exp_bus   = '0;
    init_bank = 1'b1;

    @(negedge clock);
    @(negedge clock);
    check("rst.bus", BusMuxOut, 32'd0);
    check("rst.enable", 32'(enable), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    init_bank = 1'b0;
    clear     = 1'b0;
    @(negedge clock);
    check("rst.ready", 32'(req_ready), 32'd1);

    // Table-driven transfers, including out-of-range indices.
    for (int k = 0; k < 8; k++) run_xfer(vecs[k].src, vecs[k].dst, vecs[k].exp_err);

    // Back-to-back erroneous requests are accepted every cycle.
    run_xfer(4'd14, 4'd1, 1'b1);
    run_xfer(4'd2, 4'd12, 1'b1);

    // Asynchronous clear mid-cycle while idle with a non-zero bus.
    #3 clear = 1'b1;
    #1;
    check("aclr.bus", BusMuxOut, 32'd0);
    check("aclr.enable", 32'(enable), 32'd0);
    check("aclr.ready", 32'(req_ready), 32'd1);
    exp_bus = '0;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // Back-to-back: valid held, second request accepted three cycles after the first.
    r1_orig = exp_regs[1];
    acc_q.delete();
    req_valid = 1'b1;
    req_src   = 4'd1;
    req_dst   = 4'd2;
    n = 0;
    while (acc_q.size() < 1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    req_src = 4'd2;
    req_dst = 4'd4;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    req_valid = 1'b0;
    check("b2b.accepts", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) check("b2b.spacing", 32'(acc_q[1] - acc_q[0]), 32'd3);
    @(negedge clock);
    @(negedge clock);
    exp_regs[2] = r1_orig;
    exp_regs[4] = r1_orig;
    exp_bus     = r1_orig;
    check("b2b.r2", bank[2], r1_orig);
    check("b2b.r4", bank[4], r1_orig);
    check("b2b.bus", BusMuxOut, r1_orig);

    // Clear during WRITE: enable drops at once, destination keeps its value.
    req_valid = 1'b1;
    req_src   = 4'd5;
    req_dst   = 4'd9;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("wclr.in_write", 32'(enable), 32'd1 << 9);
    #2 clear = 1'b1;
    #1;
    check("wclr.enable", 32'(enable), 32'd0);
    check("wclr.done", 32'(done), 32'd0);
    check("wclr.ready", 32'(req_ready), 32'd1);
    exp_bus = '0;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("wclr.dst_kept", bank[9], exp_regs[9]);
    check("wclr.bus", BusMuxOut, 32'd0);
    check("wclr.idle", 32'(req_ready), 32'd1);

`ifdef BUS_IMM_EN
    // Immediate source: src out of range is not an error when req_imm_sel=1.
    req_imm_sel = 1'b1;
    req_imm     = 32'h12345678;
    req_valid   = 1'b1;
    req_src     = 4'd15;
    req_dst     = 4'd0;
    @(negedge clock);
    req_valid   = 1'b0;
    req_imm_sel = 1'b0;
    check("imm.err", 32'(err), 32'd0);
    @(negedge clock);
    check("imm.bus", BusMuxOut, 32'h12345678);
    check("imm.enable", 32'(enable), 32'd1);
    @(negedge clock);
    check("imm.enable_off", 32'(enable), 32'd0);
    check("imm.r0", bank[0], 32'h12345678);
    exp_regs[0] = 32'h12345678;
    exp_bus     = 32'h12345678;
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] s;
      logic [3:0] d;
      int         gap;
      s   = 4'($urandom_range(0, 15));
      d   = 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 2);
      run_xfer(s, d, (int'(s) >= NR) || (int'(d) >= NR));
      for (int g = 0; g < gap; g++) @(negedge clock);
    end

    for (int i = 0; i < NR; i++) check("final.bank", bank[i], exp_regs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
